irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Prioritising interrupt controller between peripheral event sources (timer, UART RX/TX, switch) and the
//  single-cycle core's Interrupt input. Latches source events as pending bits, applies a software mask and
//  raises one registered irq request while the core is in user mode (PC[31]==0).
//  Tracks the in-service source until the handler returns. Memory-mapped in the peripheral window; rdata is
//  ORed into the core's ReadData bus.
// PARAMETERS
//  NUM_SRC    4             number of interrupt sources (1..8); src[0] has highest priority
//  BASE_ADDR  32'h40000030  byte address of PEND; MASK at +4, CAUSE at +8
// PORTS
//  clk          in   1        core clock (same as PC/RegFile clock)
//  reset        in   1        asynchronous, active-low
//  src          in   NUM_SRC  level event sources, synchronous to clk
//  kernel_mode  in   1        PC[31] of the core
//  irq_taken    in   1        high for the cycle the core loads PC<=0x80000004
//  mem_rd       in   1        read strobe (MemRd1 path)
//  mem_wr       in   1        write strobe (MemWr1 path)
//  addr         in   32       byte address (ALUOut)
//  wdata        in   32       write data (DatabusB)
//  rdata        out  32       read data; 0 when not selected
//  irq          out  1        interrupt request to core
//  busy         out  1        high while a source is in service
// BEHAVIOUR
//  Reset (async, reset==0): PEND=0, MASK=0, CAUSE=0, src_d=0, kmode_d=0, state=IDLE, irq=0, busy=0.
//  Registers (all update on posedge clk):
//   PEND[NUM_SRC-1:0]: bit i set when src[i]&~src_d[i] (rising edge).
//     Write to PEND is write-1-to-clear. Set and clear of the same bit in one cycle: set wins.
//   MASK[NUM_SRC-1:0]: read/write; 1 = enabled. Upper bits read 0, writes to them ignored.
//   CAUSE: [31]=valid, [2:0]=id of in-service source; read-only, writes ignored.
//  Decode: selected iff addr==BASE_ADDR+{0,4,8}. Other addresses/unaligned: no effect, rdata=0.
//   rdata is combinational (same-cycle read for the single-cycle core), 0 unless mem_rd and selected.
//  active = PEND & MASK; win = lowest-index set bit of active.
//  FSM:
//   IDLE:
//     if |active && !kernel_mode: irq<=1, state<=REQ.
//   REQ (irq held 1):
//     irq_taken: irq<=0, CAUSE<={1'b1,...,win} using win of that cycle; PEND[win]<=0; busy<=1;
//       state<=SERVICE.
//     else if active becomes 0 (software cleared/masked before acceptance): irq<=0, state<=IDLE.
//     kernel_mode==1 without irq_taken (exception entry won): irq<=0, state<=IDLE. Pending bits are kept.
//   SERVICE:
//     irq stays 0 regardless of new events; new events still set PEND.
//     On falling edge of kernel_mode (kmode_d==1 && kernel_mode==0, i.e. jr $26 return): busy<=0,
//       CAUSE[31]<=0, state<=IDLE.
//     Re-request is possible from the next cycle.
//  Latency: src rising edge at cycle n -> PEND set at n+1 -> irq high at n+2 (if enabled and in user mode).
//  No nesting: one source in service at a time. Priority is fixed, not rotating.
//  Reset mid-operation returns immediately to IDLE with irq=0; pending events are discarded.
// TESTING
//  1: MASK=4'b1111, pulse src[2] one cycle at n -> PEND=4'b0100 at n+1, irq=1 at n+2; irq_taken ->
//     CAUSE=0x80000002, PEND=0, irq=0, busy=1.
//  2: src[3] and src[1] rise together, MASK=4'b1111 -> CAUSE id=1 after take. After kernel_mode 1->0,
//     irq re-asserts within 2 cycles; second take gives CAUSE id=3.
//  3: MASK=4'b0001, src[1] pulses -> PEND=4'b0010, irq stays 0. Write MASK=4'b0011 -> irq=1 two cycles later.
//  4: irq high in REQ, software writes PEND=0xF before irq_taken -> irq=0 next cycle, state IDLE.
//     Same-cycle src[0] edge during that write -> PEND[0]=1 (set wins).
//  5: kernel_mode=1, src[0] pulses -> no irq. kernel_mode 1->0 -> irq=1 next cycle.
//  6: drive reset=0 asynchronously while in SERVICE with PEND!=0 -> irq, busy, PEND, MASK, CAUSE all 0
//     without a clock edge.

Source files
------------

// File: rtl/irq_controller.sv
// Prioritising interrupt controller for the single-cycle core.
// It latches rising edges from the sources as pending bits and applies a software mask. It raises one
// registered request while the core runs in user mode. It then tracks the source in service until the
// handler returns. Its registers sit in the peripheral window, and rdata is ORed onto the core read bus.
module irq_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               kernel_mode,
  input  logic               irq_taken,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq,
  output logic               busy
);

  localparam logic [31:0] PendAddr  = BASE_ADDR;
  localparam logic [31:0] MaskAddr  = BASE_ADDR + 32'd4;
  localparam logic [31:0] CauseAddr = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] src_q;
  logic               kmode_q;
  logic               cause_valid_q, cause_valid_d;
  logic [2:0]         cause_id_q, cause_id_d;
  logic               irq_q, busy_q;

  logic               sel_pend, sel_mask, sel_cause;
  logic               take;
  logic [2:0]         win;
  logic [NUM_SRC-1:0] rise, clr_sw, clr_take, active, active_nxt;

  // Only the upper data bits beyond the source count are never consumed.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Exact word-address decode; anything else (including unaligned) is ignored.
  always_comb begin
    sel_pend  = (addr == PendAddr);
    sel_mask  = (addr == MaskAddr);
    sel_cause = (addr == CauseAddr);
  end

  // Lowest-index enabled pending source wins.
  always_comb begin
    active = pend_q & mask_q;
    win    = 3'd0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) win = 3'(i);
    end
  end

  // Pending/mask next state: event set beats a W1C or acceptance clear of the same bit.
  always_comb begin
    take   = (state_q == StReq) && irq_taken;
    rise   = src & ~src_q;
    clr_sw = (mem_wr && sel_pend) ? wdata[NUM_SRC-1:0] : '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      clr_take[i] = take && (win == 3'(i));
    end
    pend_d     = (pend_q & ~clr_sw & ~clr_take) | rise;
    mask_d     = (mem_wr && sel_mask) ? wdata[NUM_SRC-1:0] : mask_q;
    active_nxt = pend_d & mask_d;
  end

  // Request/service sequencing and CAUSE capture.
  always_comb begin
    state_d       = state_q;
    cause_valid_d = cause_valid_q;
    cause_id_d    = cause_id_q;
    unique case (state_q)
      StIdle: begin
        if (|active && !kernel_mode) state_d = StReq;
      end
      StReq: begin
        if (irq_taken) begin
          state_d       = StService;
          cause_valid_d = 1'b1;
          cause_id_d    = win;
        end else if (active_nxt == '0 || kernel_mode) begin
          // Withdrawn by software, or an exception entry beat us; pending bits stay.
          state_d = StIdle;
        end
      end
      StService: begin
        // Handler return (jr $26) shows up as a falling edge of kernel mode.
        if (kmode_q && !kernel_mode) begin
          state_d       = StIdle;
          cause_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, register file and edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pend_q        <= '0;
      mask_q        <= '0;
      src_q         <= '0;
      kmode_q       <= 1'b0;
      cause_valid_q <= 1'b0;
      cause_id_q    <= 3'd0;
      irq_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      src_q         <= src;
      kmode_q       <= kernel_mode;
      cause_valid_q <= cause_valid_d;
      cause_id_q    <= cause_id_d;
      irq_q         <= (state_d == StReq);
      busy_q        <= (state_d == StService);
    end
  end

  assign irq  = irq_q;
  assign busy = busy_q;

  // Same-cycle read path; zero unless this block is addressed.
  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      if (sel_pend) begin
        rdata[NUM_SRC-1:0] = pend_q;
      end else if (sel_mask) begin
        rdata[NUM_SRC-1:0] = mask_q;
      end else if (sel_cause) begin
        rdata = {cause_valid_q, 28'd0, cause_id_q};
      end
    end
  end

endmodule
